// File: rtl/bramwrapper_pingpong_input.sv
// Ping-pong input feature-map buffer: two RAM banks, one filled while the other is read,
// with fully pipelined reads and a show-ahead output FIFO under valid/ready backpressure.
module bramwrapper_pingpong_input #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = READ_LATENCY + 2
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    input  logic                  rd_done,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic                  err_sticky
);

    localparam int unsigned BANK_DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned INF_W      = $clog2(READ_LATENCY + 1) + 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned SUM_W      = ((INF_W > CNT_W) ? INF_W : CNT_W) + 1;

    // Bank storage (not reset) and read pipeline
    logic [DATA_WIDTH-1:0] mem_q   [2][BANK_DEPTH];
    logic [DATA_WIDTH-1:0] pdata_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] pvld_q;

    // Output FIFO storage; the head is mirrored in dout_q
    logic [DATA_WIDTH-1:0] fifo_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      cnt_q,  cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvld_q, dvld_d;

    // Bank bookkeeping and credit
    logic [1:0]       full_q,     full_d;
    logic             wr_bank_q,  wr_bank_d;
    logic             rd_bank_q,  rd_bank_d;
    logic             wr_ready_q, wr_ready_d;
    logic             rd_ready_q, rd_ready_d;
    logic             err_q,      err_d;
    logic [INF_W-1:0] inflight_q, inflight_d;

    logic                  wr_fire;
    logic                  wr_hand;
    logic                  rd_fire;
    logic                  rd_rel;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    assign wr_fire = wr_en && wr_ready_q;
    assign wr_hand = wr_done && wr_ready_q;
    assign rd_fire = rd_en && rd_ready_q;
    assign rd_rel  = rd_done && full_q[rd_bank_q];
    assign push    = pvld_q[READ_LATENCY-1];
    assign pop     = dvld_q && dout_ready;

    always_ff @(posedge iclk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_addr] <= wr_data;
        end
    end

    // RAM is sampled at issue, so a later bank release cannot corrupt in-flight reads
    always_ff @(posedge iclk) begin
        if (rd_fire) begin
            pdata_q[0] <= mem_q[rd_bank_q][rd_addr];
        end
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pdata_q[i] <= pdata_q[i-1];
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            pvld_q <= '0;
        end else begin
            pvld_q[0] <= rd_fire;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pvld_q[i] <= pvld_q[i-1];
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (push) begin
            fifo_q[wptr_q] <= pdata_q[READ_LATENCY-1];
        end
    end

    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        err_d      = err_q;
        inflight_d = inflight_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        head       = '0;
        dvld_d     = 1'b0;
        dout_d     = '0;
        wr_ready_d = 1'b0;
        rd_ready_d = 1'b0;

        // Handoff and release target different banks, or the same bank in opposite states
        if (wr_hand) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (rd_rel) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        if ((wr_en && !wr_ready_q) || (wr_done && !wr_ready_q) ||
            (rd_en && !rd_ready_q) || (rd_done && !full_q[rd_bank_q])) begin
            err_d = 1'b1;
        end

        inflight_d = inflight_q + INF_W'(rd_fire) - INF_W'(push);
        cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);

        if (push) begin
            wptr_d = (wptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
        end

        // New head bypasses storage when the FIFO drains to empty in the push cycle
        head = fifo_q[rptr_d];
        if ((cnt_q - CNT_W'(pop)) == '0) begin
            head = pdata_q[READ_LATENCY-1];
        end
        dvld_d = (cnt_d != '0);
        dout_d = dvld_d ? head : '0;

        wr_ready_d = !full_d[wr_bank_d];
        rd_ready_d = full_d[rd_bank_d] &&
                     ((SUM_W'(inflight_d) + SUM_W'(cnt_d)) < SUM_W'(FIFO_DEPTH));
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            dvld_q     <= 1'b0;
            dout_q     <= '0;
            wr_ready_q <= 1'b1;
            rd_ready_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            dvld_q     <= dvld_d;
            dout_q     <= dout_d;
            wr_ready_q <= wr_ready_d;
            rd_ready_q <= rd_ready_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign rd_ready   = rd_ready_q;
    assign dout_valid = dvld_q;
    assign dout       = dout_q;
    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_bramwrapper_pingpong_input.sv
// Self-checking bench for bramwrapper_pingpong_input: directed ping-pong scenarios plus
// randomized traffic, checked every cycle against a queue-based behavioural model.
module tb_bramwrapper_pingpong_input;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 11;
    localparam int unsigned RL = 2;
    localparam int unsigned FD = RL + 2;

    logic          iclk = 1'b0;
    logic          irst;
    logic          wr_en, wr_done, rd_en, rd_done, dout_ready;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready, rd_ready, dout_valid, wr_bank, rd_bank, err_sticky;
    logic [DW-1:0] dout;

    always #5 iclk = ~iclk;

    bramwrapper_pingpong_input #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL),
        .FIFO_DEPTH  (FD)
    ) dut (
        .iclk      (iclk),
        .irst      (irst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .wr_ready  (wr_ready),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_done   (rd_done),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout      (dout),
        .wr_bank   (wr_bank),
        .rd_bank   (rd_bank),
        .err_sticky(err_sticky)
    );

    // Reference model: bank contents, bank flags, in-flight reads (with due cycle), FIFO queue
    typedef struct { int due; logic [DW-1:0] d; bit k; } pent_t;
    typedef struct { logic [DW-1:0] d; bit k; } fent_t;

    logic [DW-1:0] mm [2][2**AW];
    bit            mk [2][2**AW];
    bit [1:0]      m_full;
    bit            m_wb, m_rb, m_err;
    pent_t         m_pq[$];
    fent_t         m_fq[$];

    int            cyc;
    logic [DW-1:0] got[$];
    int            got_step[$];
    int            n_vec, n_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_full = '0;
        m_wb   = 1'b0;
        m_rb   = 1'b0;
        m_err  = 1'b0;
        m_pq.delete();
        m_fq.delete();
    endtask

    function automatic bit m_wr_ready();
        return !m_full[m_wb];
    endfunction

    function automatic bit m_rd_ready();
        return m_full[m_rb] && ((m_pq.size() + m_fq.size()) < int'(FD));
    endfunction

    task automatic compare_outputs();
        check_eq("wr_ready", 32'(wr_ready), 32'(m_wr_ready()));
        check_eq("rd_ready", 32'(rd_ready), 32'(m_rd_ready()));
        check_eq("wr_bank", 32'(wr_bank), 32'(m_wb));
        check_eq("rd_bank", 32'(rd_bank), 32'(m_rb));
        check_eq("err_sticky", 32'(err_sticky), 32'(m_err));
        check_eq("dout_valid", 32'(dout_valid), 32'(m_fq.size() != 0));
        if (m_fq.size() == 0) check_eq("dout_idle", 32'(dout), 32'(0));
        else if (m_fq[0].k)   check_eq("dout", 32'(dout), 32'(m_fq[0].d));
    endtask

    // One clock cycle: check outputs, drive inputs, then advance the model across the edge
    task automatic step(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit wdn, input bit re, input logic [AW-1:0] ra,
                        input bit rdn, input bit dr);
        bit    wrdy, rrdy, pop, rel_ok;
        pent_t pe;
        fent_t fe;
        compare_outputs();
        if (dout_valid && dr) begin
            got.push_back(dout);
            got_step.push_back(cyc);
        end
        wr_en = we; wr_addr = wa; wr_data = wd; wr_done = wdn;
        rd_en = re; rd_addr = ra; rd_done = rdn; dout_ready = dr;
        wrdy   = m_wr_ready();
        rrdy   = m_rd_ready();
        pop    = (m_fq.size() != 0) && dr;
        rel_ok = m_full[m_rb];
        @(posedge iclk);
        if (pop) void'(m_fq.pop_front());
        while (m_pq.size() != 0 && m_pq[0].due == cyc) begin
            pe   = m_pq.pop_front();
            fe.d = pe.d;
            fe.k = pe.k;
            m_fq.push_back(fe);
        end
        if (re && rrdy) begin
            pe.due = cyc + int'(RL);
            pe.d   = mm[m_rb][ra];
            pe.k   = mk[m_rb][ra];
            m_pq.push_back(pe);
        end else if (re) begin
            m_err = 1'b1;
        end
        if (we && wrdy) begin
            mm[m_wb][wa] = wd;
            mk[m_wb][wa] = 1'b1;
        end else if (we) begin
            m_err = 1'b1;
        end
        if (wdn && !wrdy)   m_err = 1'b1;
        if (rdn && !rel_ok) m_err = 1'b1;
        if (wdn && wrdy) begin
            m_full[m_wb] = 1'b1;
            m_wb         = !m_wb;
        end
        if (rdn && rel_ok) begin
            m_full[m_rb] = 1'b0;
            m_rb         = !m_rb;
        end
        cyc++;
        @(negedge iclk);
    endtask

    task automatic idle(input bit dr);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, dr);
    endtask

    initial begin
        int acc;
        int issue_step;
        bit r;
        n_vec = 0; n_err = 0; cyc = 0;
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_done = 0;
        rd_en = 0; rd_addr = '0; rd_done = 0; dout_ready = 0;
        irst = 1'b1;
        model_reset();
        repeat (3) @(negedge iclk);
        compare_outputs();
        irst = 1'b0;
        repeat (2) idle(1'b0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'(1));
        check_eq("rst_rd_ready", 32'(rd_ready), 32'(0));
        check_eq("rst_dout", 32'(dout), 32'(0));

        // Fill bank0 and stream 8 reads with the sink always ready
        for (int k = 0; k < 8; k++) step(1'b1, AW'(k), DW'(16'h1000 + k), 1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        check_eq("handoff_wr_bank", 32'(wr_bank), 32'(1));
        check_eq("handoff_rd_ready", 32'(rd_ready), 32'(1));
        got.delete(); got_step.delete();
        issue_step = cyc;
        for (int k = 0; k < 8; k++) step(1'b0, '0, '0, 1'b0, 1'b1, AW'(k), 1'b0, 1'b1);
        repeat (6) idle(1'b1);
        check_eq("stream_count", 32'(got.size()), 32'(8));
        for (int k = 0; k < 8 && k < got.size(); k++) check_eq("stream_word", 32'(got[k]), 32'(16'h1000 + k));
        if (got.size() == 8) begin
            check_eq("first_latency", 32'(got_step[0] - issue_step), 32'(RL + 1));
            check_eq("no_gaps", 32'(got_step[7] - got_step[0]), 32'(7));
        end

        // Backpressure: only FD reads fit while the sink stalls
        got.delete();
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            r = rd_ready;
            step(1'b0, '0, '0, 1'b0, r, AW'(acc), 1'b0, 1'b0);
            if (r) acc++;
        end
        check_eq("credit_accepts", 32'(acc), 32'(FD));
        check_eq("credit_stall", 32'(rd_ready), 32'(0));
        repeat (8) idle(1'b1);
        check_eq("drain_count", 32'(got.size()), 32'(FD));
        for (int k = 0; k < int'(FD) && k < got.size(); k++) check_eq("drain_word", 32'(got[k]), 32'(16'h1000 + k));
        check_eq("credit_return", 32'(rd_ready), 32'(1));

        // Ping-pong: fill bank1 while reading bank0, then swap both in one cycle
        got.delete();
        for (int k = 0; k < 8; k++) step(1'b1, AW'(k), DW'(16'h2000 + k), 1'b0, 1'b1, AW'(k), 1'b0, 1'b1);
        repeat (4) idle(1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        check_eq("swap_rd_bank", 32'(rd_bank), 32'(1));
        check_eq("swap_wr_bank", 32'(wr_bank), 32'(0));
        check_eq("swap_wr_ready", 32'(wr_ready), 32'(1));
        got.delete();
        for (int k = 0; k < 8; k++) step(1'b1, AW'(k), DW'(16'h3000 + k), 1'b0, 1'b1, AW'(k), 1'b0, 1'b1);
        repeat (6) idle(1'b1);
        check_eq("bank1_count", 32'(got.size()), 32'(8));
        for (int k = 0; k < 8 && k < got.size(); k++) check_eq("bank1_word", 32'(got[k]), 32'(16'h2000 + k));
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Errors: write with both banks full, read with no full bank
        check_eq("err_clean", 32'(err_sticky), 32'(0));
        step(1'b1, '0, 16'hDEAD, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_eq("err_drop_write", 32'(err_sticky), 32'(1));
        got.delete();
        step(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0, 1'b1);
        repeat (4) idle(1'b1);
        check_eq("intact_count", 32'(got.size()), 32'(1));
        if (got.size() == 1) check_eq("intact_word", 32'(got[0]), 32'(16'h2000));
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, AW'(3), 1'b0, 1'b1);
        check_eq("err_drop_read", 32'(err_sticky), 32'(1));
        repeat (4) idle(1'b1);
        check_eq("drop_no_word", 32'(got.size()), 32'(1));

        // Reset with reads both in flight and queued
        for (int k = 0; k < 4; k++) step(1'b1, AW'(k), DW'(16'h4000 + k), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, '0, '0, 1'b0, 1'b1, AW'(k), 1'b0, 1'b0);
        check_eq("pre_rst_valid", 32'(dout_valid), 32'(1));
        wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
        irst = 1'b1;
        #1;
        check_eq("rst_async_valid", 32'(dout_valid), 32'(0));
        check_eq("rst_async_dout", 32'(dout), 32'(0));
        model_reset();
        repeat (2) @(negedge iclk);
        irst = 1'b0;
        got.delete();
        repeat (6) idle(1'b1);
        check_eq("post_rst_silent", 32'(got.size()), 32'(0));

        // Randomized traffic, checked cycle-by-cycle against the model
        for (int i = 0; i < 1500; i++) begin
            bit we, re;
            we = ($urandom_range(0, 3) != 0) && (wr_ready || ($urandom_range(0, 40) == 0));
            re = ($urandom_range(0, 2) != 0) && (rd_ready || ($urandom_range(0, 40) == 0));
            step(we, AW'($urandom_range(0, 31)), DW'($urandom), ($urandom_range(0, 15) == 0),
                 re, AW'($urandom_range(0, 31)), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        repeat (8) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
